cook_timer_mmss: RTL and testbench

Minutes:seconds countdown timer that consumes the one-cycle second tick from the clock-divider chain and counts a user-set BCD value down to 00:00, then raises an alarm. It is the down-counting counterpart to the up-counting watch: the watch time base feeds `clk_sec`, and the four BCD digits drive the FND display mux directly. A preset register holds the last started value so it can be re-run after the alarm.

---
 rtl/cook_timer_mmss.sv | 154 +++++++++++++++
 tb/tb_cook_timer_mmss.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cook_timer_mmss.sv
// Minutes:seconds countdown timer. The user sets a BCD value, starts it,
// and it counts down once per clk_sec tick to 00:00, then raises an alarm.
// The preset keeps the last started value so it can be re-run after the
// alarm or recalled from 00:00.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | stopped; set buttons edit the value, start launches RUN
// S_RUN   | counting down on clk_sec
// S_PAUSE | frozen mid-count; set buttons edit, start resumes
// S_ALARM | value is 00:00, alarm high until ack or ALARM_SEC ticks
module cook_timer_mmss #(
  parameter int ALARM_SEC = 10,
  parameter int MAX_MIN   = 59
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       clk_sec,
  input  logic       btn_start,
  input  logic       btn_set_min,
  input  logic       btn_set_sec,
  input  logic       btn_clear,
  output logic [3:0] min10,
  output logic [3:0] min1,
  output logic [3:0] sec10,
  output logic [3:0] sec1,
  output logic       running,
  output logic       alarm
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_ALARM = 2'd3;

  localparam logic [3:0] MAX_M10    = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_M1     = 4'(MAX_MIN % 10);
  // The counter holds ticks already seen, so the last tick arrives when it
  // equals ALARM_SEC-1.
  localparam logic [5:0] ALARM_LAST = 6'(ALARM_SEC - 1);

  logic [1:0]  state;
  logic [15:0] preset;
  logic [5:0]  tick_cnt;

  logic [15:0] value;
  logic        value_zero;
  logic        preset_zero;
  logic        one_left;
  logic        any_set;
  logic [7:0]  sec_inc;
  logic [7:0]  min_inc;
  logic [15:0] value_dec;

  assign value       = {min10, min1, sec10, sec1};
  assign value_zero  = (value == 16'h0000);
  assign preset_zero = (preset == 16'h0000);
  assign one_left    = (value == 16'h0001);
  assign any_set     = btn_set_min | btn_set_sec;
  assign running     = (state == S_RUN);
  assign alarm       = (state == S_ALARM);

  // BCD increment of each settable field, with its own wrap point.
  always_comb begin
    sec_inc = {sec10, sec1};
    min_inc = {min10, min1};
    if (sec10 == 4'd5 && sec1 == 4'd9)  sec_inc = 8'h00;
    else if (sec1 == 4'd9)              sec_inc = {sec10 + 4'd1, 4'd0};
    else                                sec_inc = {sec10, sec1 + 4'd1};
    if (min10 == MAX_M10 && min1 == MAX_M1) min_inc = 8'h00;
    else if (min1 == 4'd9)                  min_inc = {min10 + 4'd1, 4'd0};
    else                                    min_inc = {min10, min1 + 4'd1};
  end

  // One-second BCD decrement with borrow from sec1 up to min10.
  always_comb begin
    value_dec = value;
    if (sec1 != 4'd0) begin
      value_dec[3:0] = sec1 - 4'd1;
    end else begin
      value_dec[3:0] = 4'd9;
      if (sec10 != 4'd0) begin
        value_dec[7:4] = sec10 - 4'd1;
      end else begin
        value_dec[7:4] = 4'd5;
        if (min1 != 4'd0) begin
          value_dec[11:8] = min1 - 4'd1;
        end else begin
          value_dec[11:8]  = 4'd9;
          value_dec[15:12] = min10 - 4'd1;
        end
      end
    end
  end

  // State, digits, preset and alarm tick counter.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state                     <= S_IDLE;
      {min10, min1, sec10, sec1} <= 16'h0000;
      preset                    <= 16'h0000;
      tick_cnt                  <= 6'd0;
    end else if (btn_clear) begin
      state                     <= S_IDLE;
      {min10, min1, sec10, sec1} <= 16'h0000;
      preset                    <= 16'h0000;
    end else begin
      case (state)
        S_IDLE, S_PAUSE: begin
          if (btn_start) begin
            if (!value_zero) begin
              state <= S_RUN;
              if (state == S_IDLE) preset <= value;
            end else if (state == S_IDLE && !preset_zero) begin
              state                     <= S_RUN;
              {min10, min1, sec10, sec1} <= preset;
            end
          end else begin
            if (btn_set_sec) {sec10, sec1} <= sec_inc;
            if (btn_set_min) {min10, min1} <= min_inc;
          end
        end
        S_RUN: begin
          if (clk_sec && !value_zero) begin
            {min10, min1, sec10, sec1} <= value_dec;
            if (one_left) begin
              state    <= S_ALARM;
              tick_cnt <= 6'd0;
            end else if (btn_start) begin
              state <= S_PAUSE;
            end
          end else if (btn_start) begin
            state <= S_PAUSE;
          end
        end
        S_ALARM: begin
          if (btn_start || any_set) begin
            state                     <= S_IDLE;
            {min10, min1, sec10, sec1} <= preset;
          end else if (clk_sec) begin
            if (tick_cnt == ALARM_LAST) begin
              state                     <= S_IDLE;
              {min10, min1, sec10, sec1} <= preset;
            end else begin
              tick_cnt <= tick_cnt + 6'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cook_timer_mmss.sv
// Directed bench for cook_timer_mmss. A seconds-based model tracks the
// expected value every cycle; literal checks pin the model at key points.
module tb_cook_timer_mmss;

  localparam int ALARM_SEC = 10;
  localparam int MAX_MIN   = 59;

  localparam logic [5:0] NONE  = 6'b000000;
  localparam logic [5:0] B_CS  = 6'b000001;
  localparam logic [5:0] B_SS  = 6'b000010;
  localparam logic [5:0] B_SM  = 6'b000100;
  localparam logic [5:0] B_ST  = 6'b001000;
  localparam logic [5:0] B_CLR = 6'b010000;
  localparam logic [5:0] B_RST = 6'b100000;

  logic clk = 1'b0;
  logic reset_p = 1'b0, clk_sec = 1'b0, btn_start = 1'b0;
  logic btn_set_min = 1'b0, btn_set_sec = 1'b0, btn_clear = 1'b0;
  logic [3:0] min10, min1, sec10, sec1;
  logic running, alarm;

  cook_timer_mmss #(.ALARM_SEC(ALARM_SEC), .MAX_MIN(MAX_MIN)) dut (
    .clk(clk), .reset_p(reset_p), .clk_sec(clk_sec), .btn_start(btn_start),
    .btn_set_min(btn_set_min), .btn_set_sec(btn_set_sec), .btn_clear(btn_clear),
    .min10(min10), .min1(min1), .sec10(sec10), .sec1(sec1),
    .running(running), .alarm(alarm)
  );

  always #5 clk = ~clk;

  // Model: value and preset kept as minutes and seconds integers.
  int m_min = 0, m_sec = 0, p_min = 0, p_sec = 0, m_ticks = 0;
  int m_st = 0; // 0 idle, 1 run, 2 pause, 3 alarm
  bit armed = 1'b0;
  int vectors = 0, miscompares = 0;

  function automatic void model_step(logic [5:0] v);
    int total;
    total = m_min * 60 + m_sec;
    if (v[5]) begin
      m_min = 0; m_sec = 0; p_min = 0; p_sec = 0; m_ticks = 0; m_st = 0;
    end else if (v[4]) begin
      m_min = 0; m_sec = 0; p_min = 0; p_sec = 0; m_st = 0;
    end else begin
      case (m_st)
        0, 2: begin
          if (v[3]) begin
            if (total != 0) begin
              if (m_st == 0) begin p_min = m_min; p_sec = m_sec; end
              m_st = 1;
            end else if (m_st == 0 && (p_min * 60 + p_sec) != 0) begin
              m_min = p_min; m_sec = p_sec; m_st = 1;
            end
          end else begin
            if (v[1]) m_sec = (m_sec + 1) % 60;
            if (v[2]) m_min = (m_min + 1) % (MAX_MIN + 1);
          end
        end
        1: begin
          if (v[0] && total > 0) begin
            total = total - 1;
            m_min = total / 60; m_sec = total % 60;
            if (total == 0) begin m_st = 3; m_ticks = 0; end
            else if (v[3]) m_st = 2;
          end else if (v[3]) m_st = 2;
        end
        default: begin
          if (v[3] || v[2] || v[1]) begin
            m_st = 0; m_min = p_min; m_sec = p_sec;
          end else if (v[0]) begin
            m_ticks++;
            if (m_ticks == ALARM_SEC) begin
              m_st = 0; m_min = p_min; m_sec = p_sec;
            end
          end
        end
      endcase
    end
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      vectors++;
      if (min10 !== 4'(m_min / 10) || min1 !== 4'(m_min % 10) ||
          sec10 !== 4'(m_sec / 10) || sec1 !== 4'(m_sec % 10) ||
          running !== (m_st == 1) || alarm !== (m_st == 3)) begin
        miscompares++;
        $display("FAIL cycle_model t=%0t got %h%h:%h%h run=%b alm=%b want %02d:%02d run=%b alm=%b",
                 $time, min10, min1, sec10, sec1, running, alarm,
                 m_min, m_sec, m_st == 1, m_st == 3);
      end
    end
  end

  task automatic cyc(input logic [5:0] v);
    {reset_p, btn_clear, btn_start, btn_set_min, btn_set_sec, clk_sec} = v;
    @(posedge clk);
    model_step(v);
    #1;
    {reset_p, btn_clear, btn_start, btn_set_min, btn_set_sec, clk_sec} = NONE;
  endtask

  task automatic rep(input int n, input logic [5:0] v);
    for (int i = 0; i < n; i++) cyc(v);
  endtask

  task automatic lit(input string name, input int em, input int es,
                     input bit er, input bit ea);
    vectors++;
    if (min10 !== 4'(em / 10) || min1 !== 4'(em % 10) ||
        sec10 !== 4'(es / 10) || sec1 !== 4'(es % 10) ||
        running !== er || alarm !== ea) begin
      miscompares++;
      $display("FAIL %s got %h%h:%h%h run=%b alm=%b want %02d:%02d run=%b alm=%b",
               name, min10, min1, sec10, sec1, running, alarm, em, es, er, ea);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    cyc(B_RST);
    armed = 1'b1;
    lit("reset", 0, 0, 0, 0);
    rep(3, B_CS);
    lit("idle_tick_no_effect", 0, 0, 0, 0);

    // Set wrap
    rep(61, B_SS);
    rep(3, B_SM);
    lit("set_0301", 3, 1, 0, 0);
    rep(60, B_SM);
    lit("min_wrap", 3, 1, 0, 0);
    cyc(B_SM | B_SS);
    lit("both_set", 4, 2, 0, 0);

    // Borrow chain
    cyc(B_CLR);
    rep(10, B_SM);
    cyc(B_ST);
    lit("start_1000", 10, 0, 1, 0);
    rep(3, NONE);
    cyc(B_CS);
    lit("borrow_0959", 9, 59, 1, 0);

    // Expiry and timeout
    cyc(B_CLR);
    rep(2, B_SS);
    cyc(B_ST);
    cyc(B_CS);
    rep(2, NONE);
    cyc(B_CS);
    lit("expire_alarm", 0, 0, 0, 1);
    for (int i = 0; i < ALARM_SEC - 1; i++) begin
      cyc(B_CS);
      cyc(NONE);
    end
    lit("alarm_held_9", 0, 0, 0, 1);
    cyc(B_CS);
    lit("alarm_timeout", 0, 2, 0, 0);

    // Pause with simultaneous tick
    cyc(B_CLR);
    cyc(B_SM);
    rep(30, B_SS);
    cyc(B_ST);
    cyc(NONE);
    cyc(B_ST | B_CS);
    lit("pause_tick", 1, 29, 0, 0);
    rep(5, B_CS);
    lit("pause_hold", 1, 29, 0, 0);
    cyc(B_ST);
    lit("resume", 1, 29, 1, 0);

    // Acknowledge and recall
    cyc(B_CLR);
    cyc(B_SS);
    cyc(B_ST);
    cyc(B_CS);
    lit("alarm_001", 0, 0, 0, 1);
    cyc(B_SS);
    lit("ack_set_sec", 0, 1, 0, 0);
    rep(59, B_SS);
    lit("wrap_to_zero", 0, 0, 0, 0);
    cyc(B_ST);
    lit("recall_preset", 0, 1, 1, 0);
    cyc(B_CS);
    cyc(B_ST);
    lit("ack_start", 0, 1, 0, 0);

    // Clear and reset mid-run
    cyc(B_CLR);
    rep(5, B_SM);
    cyc(B_ST);
    rep(2, NONE);
    cyc(B_CLR);
    lit("clear_run", 0, 0, 0, 0);
    cyc(B_ST);
    lit("start_ignored", 0, 0, 0, 0);
    rep(5, B_SS);
    cyc(B_ST);
    cyc(B_CS);
    lit("run_0004", 0, 4, 1, 0);
    cyc(B_RST | B_CS | B_ST);
    lit("reset_mid_run", 0, 0, 0, 0);
    cyc(B_ST);
    lit("preset_cleared", 0, 0, 0, 0);
    rep(2, NONE);

    armed = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
